// File: rtl/data_cache_pkg.sv
// Shared types and defaults for the data cache and its neighbours.
package data_cache_pkg;

    localparam int unsigned LSQ_SIZE     = 8;
    localparam int unsigned DCACHE_LINES = 16;

    typedef logic [31:0] Address;
    typedef logic [31:0] MemoryWord;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL_REQ  = 3'd1,
        FILL_WAIT = 3'd2,
        WR_REQ    = 3'd3,
        WR_WAIT   = 3'd4
    } cache_state_t;

endpackage

// File: rtl/data_cache_if.sv
// Load/store port, backing-memory port and counters of the data cache.
interface data_cache_if;
    import data_cache_pkg::*;

    logic        rd_valid;
    Address      rd_addr;
    logic        data_ready1;
    MemoryWord   data_response1;

    logic        wr_valid;
    Address      wr_addr;
    MemoryWord   wr_data;
    logic        wr_ready;

    logic        mem_req;
    logic        mem_we;
    Address      mem_addr;
    MemoryWord   mem_wdata;
    logic        mem_ack;
    MemoryWord   mem_rdata;

    logic [31:0] hit_count;
    logic [31:0] miss_count;

    // Cache side.
    modport slave (
        input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data, mem_ack, mem_rdata,
        output data_ready1, data_response1, wr_ready, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, miss_count
    );

    // Pipeline/memory side.
    modport master (
        output rd_valid, rd_addr, wr_valid, wr_addr, wr_data, mem_ack, mem_rdata,
        input  data_ready1, data_response1, wr_ready, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, miss_count
    );

endinterface

// File: rtl/dcache_array.sv
// Direct-mapped valid/tag/data storage: one combinational read port, one write port.
module dcache_array
    import data_cache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned IDXW  = $clog2(LINES),
    parameter int unsigned TAGW  = 30 - IDXW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDXW-1:0] i_rd_idx,
    output logic            o_rd_valid,
    output logic [TAGW-1:0] o_rd_tag,
    output MemoryWord       o_rd_data,
    input  logic            i_wr_en,
    input  logic            i_wr_fill,   // 1: allocate line, 0: update data only on tag hit
    input  logic [IDXW-1:0] i_wr_idx,
    input  logic [TAGW-1:0] i_wr_tag,
    input  MemoryWord       i_wr_data
);

    logic [LINES-1:0] r_valid;
    logic [TAGW-1:0]  r_tag  [LINES];
    MemoryWord        r_data [LINES];
    logic             w_wr_data_en;

    // Read port and store-hit qualification.
    always_comb begin
        o_rd_valid   = r_valid[i_rd_idx];
        o_rd_tag     = r_tag[i_rd_idx];
        o_rd_data    = r_data[i_rd_idx];
        w_wr_data_en = i_wr_en &&
                       (i_wr_fill || (r_valid[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag)));
    end

    // Valid bits are the only reset state; a fill marks its line valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (i_wr_en && i_wr_fill) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage; no reset because valid gates every use.
    always_ff @(posedge clk) begin
        if (i_wr_en && i_wr_fill) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
        if (w_wr_data_en) begin
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Blocking direct-mapped write-through, no-write-allocate data cache.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int unsigned LINES = DCACHE_LINES
) (
    input  logic         clk,
    input  logic         reset,
    data_cache_if.slave  bus
);

    localparam int unsigned IDXW = $clog2(LINES);
    localparam int unsigned TAGW = 30 - IDXW;
    localparam Address      WORD_MASK = 32'hFFFF_FFFC;

    cache_state_t    r_state, w_state_next;
    Address          r_addr;
    MemoryWord       r_data;
    logic [31:0]     r_hit_count, r_miss_count;

    logic            w_line_valid;
    logic [TAGW-1:0] w_line_tag;
    MemoryWord       w_line_data;
    logic            w_hit, w_miss, w_idle, w_start_fill, w_wr_ready, w_accept, w_fill_done;
    Address          w_rd_word, w_wr_word;
    logic            w_arr_en;
    logic [IDXW-1:0] w_arr_idx;
    logic [TAGW-1:0] w_arr_tag;
    MemoryWord       w_arr_data;

    dcache_array #(
        .LINES (LINES),
        .IDXW  (IDXW),
        .TAGW  (TAGW)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx   (bus.rd_addr[2 +: IDXW]),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_arr_en),
        .i_wr_fill  (w_fill_done),
        .i_wr_idx   (w_arr_idx),
        .i_wr_tag   (w_arr_tag),
        .i_wr_data  (w_arr_data)
    );

    // Lookup, handshake decisions and array write selection.
    always_comb begin
        w_rd_word    = bus.rd_addr & WORD_MASK;
        w_wr_word    = bus.wr_addr & WORD_MASK;
        w_hit        = bus.rd_valid && w_line_valid && (w_line_tag == bus.rd_addr[31 -: TAGW]);
        w_miss       = bus.rd_valid && !w_hit;
        w_idle       = (r_state == IDLE);
        w_start_fill = w_idle && w_miss;
        // Reset gating keeps wr_ready low while reset is held.
        w_wr_ready   = reset && w_idle && !w_miss;
        w_accept     = w_wr_ready && bus.wr_valid;
        w_fill_done  = (r_state == FILL_WAIT) && bus.mem_ack;
        // Fill and store acceptance never coincide: one needs FILL_WAIT, the other IDLE.
        w_arr_en     = w_fill_done || w_accept;
        w_arr_idx    = w_fill_done ? r_addr[2 +: IDXW]   : w_wr_word[2 +: IDXW];
        w_arr_tag    = w_fill_done ? r_addr[31 -: TAGW]  : w_wr_word[31 -: TAGW];
        w_arr_data   = w_fill_done ? bus.mem_rdata       : bus.wr_data;
    end

    // Next-state logic: read miss wins over a pending store.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start_fill) begin
                    w_state_next = FILL_REQ;
                end else if (w_accept) begin
                    w_state_next = WR_REQ;
                end
            end
            FILL_REQ:  w_state_next = FILL_WAIT;
            FILL_WAIT: if (bus.mem_ack) w_state_next = IDLE;
            WR_REQ:    w_state_next = WR_WAIT;
            WR_WAIT:   if (bus.mem_ack) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // State and latched transaction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_fill) begin
                r_addr <= w_rd_word;
            end else if (w_accept) begin
                r_addr <= w_wr_word;
                r_data <= bus.wr_data;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_start_fill && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    // Output drive; memory fields read zero whenever no transaction is open.
    always_comb begin
        bus.data_ready1    = w_hit;
        bus.data_response1 = w_hit ? w_line_data : '0;
        bus.wr_ready       = w_wr_ready;
        bus.mem_req        = !w_idle;
        bus.mem_we         = (r_state == WR_REQ) || (r_state == WR_WAIT);
        bus.mem_addr       = w_idle ? '0 : r_addr;
        bus.mem_wdata      = bus.mem_we ? r_data : '0;
        bus.hit_count      = r_hit_count;
        bus.miss_count     = r_miss_count;
    end

endmodule

// File: tb/tb_data_cache.sv
// Randomized and directed bench for data_cache against a transaction-level model.
module tb_data_cache;
    import data_cache_pkg::*;

    localparam int unsigned LINES = 16;

    logic clk = 1'b0;
    logic reset;

    data_cache_if bus ();

    data_cache #(.LINES(LINES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: each line remembers the full word address it holds.
    logic        m_valid [LINES];
    logic [31:0] m_addr  [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] mem_model [logic [31:0]];
    bit          m_busy;
    bit          p_we;
    logic [31:0] p_addr, p_data;
    logic [31:0] m_hits, m_misses;

    // Memory responder state.
    bit          mem_auto = 1'b1;
    int unsigned fixed_delay = 0;
    bit          rb;
    int unsigned rcnt;
    bit          r_we;
    logic [31:0] r_addr, r_wdata;
    logic [31:0] last_req_addr;
    bit          saw_ack;

    // Per-step observations.
    bit          last_hit, last_wr_ready, accepted;
    logic [31:0] last_data;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_busy   = 1'b0;
        m_hits   = '0;
        m_misses = '0;
    endtask

    // Backing memory: acks 1..3 cycles (or fixed_delay) after seeing a request.
    task automatic respond();
        if (!reset) begin
            rb = 1'b0;
            bus.mem_ack = 1'b0;
            return;
        end
        if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            rb = 1'b0;
        end else if (!rb && bus.mem_req) begin
            rb   = 1'b1;
            rcnt = (fixed_delay != 0) ? fixed_delay : $urandom_range(1, 3);
            check_value("mem_we", bus.mem_we, p_we);
            check_value("mem_addr", bus.mem_addr, p_addr);
            if (p_we) check_value("mem_wdata", bus.mem_wdata, p_data);
            r_we = bus.mem_we;
            r_addr = bus.mem_addr;
            r_wdata = bus.mem_wdata;
            last_req_addr = bus.mem_addr;
        end else if (rb) begin
            check_value("mem_req_held", bus.mem_req, 1);
            rcnt--;
            if (rcnt == 0) begin
                bus.mem_ack = 1'b1;
                if (r_we) begin
                    mem_model[r_addr] = r_wdata;
                    bus.mem_rdata = $urandom;
                end else begin
                    bus.mem_rdata = mem_read(r_addr);
                end
            end
        end
    endtask

    // One clock cycle: respond, compare combinational outputs, advance the model.
    task automatic step();
        bit          hit;
        int unsigned line;
        logic [31:0] a;
        @(negedge clk);
        if (mem_auto) respond();
        #1;
        if (!reset) model_reset();
        a    = bus.rd_addr & 32'hFFFF_FFFC;
        line = (a >> 2) % LINES;
        hit  = reset && bus.rd_valid && m_valid[line] && (m_addr[line] == a);
        check_value("data_ready1", bus.data_ready1, hit);
        check_value("data_response1", bus.data_response1, hit ? m_data[line] : 32'h0);
        check_value("wr_ready", bus.wr_ready, reset && !m_busy && !(bus.rd_valid && !hit));
        check_value("mem_req", bus.mem_req, reset && m_busy);
        check_value("hit_count", bus.hit_count, m_hits);
        check_value("miss_count", bus.miss_count, m_misses);
        last_hit      = hit;
        last_data     = bus.data_response1;
        last_wr_ready = bus.wr_ready;
        accepted      = 1'b0;
        if (reset) begin
            if (hit) m_hits++;
            if (m_busy) begin
                if (bus.mem_ack) begin
                    saw_ack = 1'b1;
                    if (!p_we) begin
                        line = (p_addr >> 2) % LINES;
                        m_valid[line] = 1'b1;
                        m_addr[line]  = p_addr;
                        m_data[line]  = bus.mem_rdata;
                    end
                    m_busy = 1'b0;
                end
            end else if (bus.rd_valid && !hit) begin
                m_busy = 1'b1;
                p_we   = 1'b0;
                p_addr = a;
                m_misses++;
            end else if (bus.wr_valid) begin
                m_busy   = 1'b1;
                p_we     = 1'b1;
                p_addr   = bus.wr_addr & 32'hFFFF_FFFC;
                p_data   = bus.wr_data;
                accepted = 1'b1;
                line     = (p_addr >> 2) % LINES;
                if (m_valid[line] && m_addr[line] == p_addr) m_data[line] = p_data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        bus.rd_valid = 1'b0;
        bus.wr_valid = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_busy; i++) step();
        check_value("drain_idle", m_busy, 0);
    endtask

    task automatic load_until_hit(input logic [31:0] a, output logic [31:0] d, output bit ok);
        bus.rd_valid = 1'b1;
        bus.rd_addr  = a;
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            if (last_hit) begin
                ok = 1'b1;
                d  = last_data;
            end
        end
        bus.rd_valid = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, output bit ok);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            if (accepted) ok = 1'b1;
        end
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        bit          ok;
        model_reset();
        reset         = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_addr   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // Reset state.
        step();
        check_value("rst_wr_ready", bus.wr_ready, 0);
        check_value("rst_mem_we", bus.mem_we, 0);
        check_value("rst_mem_addr", bus.mem_addr, 0);
        check_value("rst_mem_wdata", bus.mem_wdata, 0);
        reset = 1'b1;
        step();

        // Cold load, ack after 3 cycles.
        mem_model[32'h100] = 32'hDEAD_BEEF;
        fixed_delay = 3;
        load_until_hit(32'h100, d, ok);
        check_value("cold_hit", ok, 1);
        check_value("cold_data", d, 32'hDEAD_BEEF);
        check_value("cold_mem_addr", last_req_addr, 32'h100);
        check_value("cold_miss_count", bus.miss_count, 1);
        check_value("cold_hit_count", bus.hit_count, 1);
        fixed_delay = 0;

        // Store hit: next-cycle load sees new data with no fill.
        do_store(32'h100, 32'h1234_5678, ok);
        check_value("st_accept", ok, 1);
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 32'h100;
        step();
        bus.rd_valid = 1'b0;
        check_value("st_hit_next", last_hit, 1);
        check_value("st_hit_data", last_data, 32'h1234_5678);
        drain();
        check_value("st_mem_word", mem_read(32'h100), 32'h1234_5678);
        check_value("st_no_fill", bus.miss_count, 1);

        // Store miss does not allocate.
        do_store(32'h200, 32'hCAFE_F00D, ok);
        check_value("stmiss_accept", ok, 1);
        drain();
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 32'h200;
        step();
        check_value("stmiss_no_alloc", last_hit, 0);
        load_until_hit(32'h200, d, ok);
        check_value("stmiss_fill_hit", ok, 1);
        check_value("stmiss_fill_data", d, 32'hCAFE_F00D);
        check_value("stmiss_miss_count", bus.miss_count, 2);

        // Read miss beats a simultaneous store.
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 32'h40;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h80;
        bus.wr_data  = 32'h0BAD_F00D;
        step();
        check_value("prio_wr_ready", last_wr_ready, 0);
        saw_ack = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            if (accepted) begin
                ok = 1'b1;
                check_value("prio_after_ack", saw_ack, 1);
                check_value("prio_load_hit", last_hit, 1);
            end
        end
        check_value("prio_accept", ok, 1);
        bus.rd_valid = 1'b0;
        bus.wr_valid = 1'b0;
        drain();

        // Conflict eviction.
        reset_dut();
        load_until_hit(32'h0, d, ok);
        check_value("conf_a_hit", ok, 1);
        load_until_hit(32'h40, d, ok);
        check_value("conf_b_hit", ok, 1);
        load_until_hit(32'h0, d, ok);
        check_value("conf_a_rehit", ok, 1);
        check_value("conf_miss_count", bus.miss_count, 3);

        // Reset during FILL_WAIT, then a stray ack.
        reset_dut();
        fixed_delay  = 10;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 32'h100;
        step();
        bus.rd_valid = 1'b0;
        step();
        step();
        check_value("rst_fw_mem_req", bus.mem_req, 1);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        mem_auto = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        step();
        bus.mem_ack = 1'b0;
        step();
        check_value("rst_fw_idle", last_wr_ready, 1);
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 32'h100;
        mem_auto    = 1'b1;
        fixed_delay = 0;
        step();
        check_value("rst_fw_no_line", last_hit, 0);
        load_until_hit(32'h100, d, ok);
        check_value("rst_fw_refill", ok, 1);

        // Randomized traffic over a few conflicting lines.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            bus.rd_valid = 1'($urandom_range(0, 1));
            bus.rd_addr  = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) |
                           $urandom_range(0, 3);
            if (!bus.wr_valid && ($urandom_range(0, 2) == 0)) begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2);
                bus.wr_data  = $urandom;
            end
            step();
            if (accepted) bus.wr_valid = 1'b0;
        end
        bus.rd_valid = 1'b0;
        bus.wr_valid = 1'b0;
        drain();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
